// File: rtl/tv_trig_gen.sv
// TV/video trigger: conditions raw HS and odd/even inputs, counts lines per field,
// and issues a one-cycle trigger on the selected video event, with arm and hold-off.

module tv_trig_filt #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic raw_in,
  output logic lvl
);
  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips only once FILT_LEN consecutive synchronised samples disagree with it.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) lvl_d = s2_q;
      else                            cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_in;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = lvl_q;
endmodule

module tv_trig_gen #(
  parameter int LINE_W   = 11,
  parameter int FILT_LEN = 4,
  parameter int HOLD_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              hs_in,
  input  logic              oe_in,
  input  logic              hs_pol,
  input  logic              oe_pol,
  input  logic [2:0]        mode,
  input  logic [1:0]        field_sel,
  input  logic [LINE_W-1:0] target_line,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              arm,
  output logic              trig,
  output logic [LINE_W-1:0] line_cnt,
  output logic              field_odd,
  output logic [LINE_W-1:0] lines_last,
  output logic              locked
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic hs_lvl, oe_lvl;
  logic hs_dly_q, oe_dly_q;
  logic hs_ev_q, hs_ev_d, odd_ev_q, odd_ev_d, even_ev_q, even_ev_d;
  logic fld_ev;

  logic [LINE_W-1:0] line_q, line_d, last_q, last_d;
  logic              fodd_q, fodd_d, locked_q, locked_d, seen_q, seen_d;
  logic              qual, hit;

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              trig_q, trig_d;

  tv_trig_filt #(.FILT_LEN(FILT_LEN)) u_hs_filt (
    .clk_in(clk_in), .rst_n(rst_n), .raw_in(hs_in ^ hs_pol), .lvl(hs_lvl)
  );
  tv_trig_filt #(.FILT_LEN(FILT_LEN)) u_oe_filt (
    .clk_in(clk_in), .rst_n(rst_n), .raw_in(oe_in ^ oe_pol), .lvl(oe_lvl)
  );

  always_comb begin
    hs_ev_d   = hs_lvl & ~hs_dly_q;
    odd_ev_d  = oe_lvl & ~oe_dly_q;
    even_ev_d = ~oe_lvl & oe_dly_q;
  end

  assign fld_ev = odd_ev_q | even_ev_q;

  // A field edge is applied before a coincident HS, so that HS becomes line 1.
  always_comb begin
    line_d   = line_q;
    fodd_d   = fodd_q;
    last_d   = last_q;
    locked_d = locked_q;
    seen_d   = seen_q;
    if (fld_ev) begin
      line_d   = '0;
      fodd_d   = odd_ev_q;
      last_d   = line_q;
      locked_d = seen_q && (line_q == last_q);
      seen_d   = 1'b1;
    end
    if (hs_ev_q && (line_d != '1)) line_d = line_d + 1'b1;
  end

  always_comb begin
    case (field_sel)
      2'b01:   qual = fodd_d;
      2'b10:   qual = ~fodd_d;
      default: qual = 1'b1;
    endcase
    case (mode)
      3'd0:    hit = even_ev_q;
      3'd1:    hit = odd_ev_q;
      3'd2:    hit = fld_ev;
      3'd3:    hit = hs_ev_q;
      3'd4:    hit = hs_ev_q && (line_d == target_line) && (target_line != '0) && qual;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    trig_d  = 1'b0;
    if (!arm) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_READY;
        ST_READY: if (hit) begin
          trig_d = 1'b1;
          if (holdoff != '0) begin
            hold_d  = holdoff;
            state_d = ST_HOLD;
          end
        end
        // Leaving on hold_q == 1 makes the earliest retrigger land holdoff+1 cycles later.
        ST_HOLD: if (hold_q <= HOLD_W'(1)) begin
          hold_d  = '0;
          state_d = ST_READY;
        end else begin
          hold_d = hold_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      hs_dly_q  <= 1'b0;
      oe_dly_q  <= 1'b0;
      hs_ev_q   <= 1'b0;
      odd_ev_q  <= 1'b0;
      even_ev_q <= 1'b0;
      line_q    <= '0;
      fodd_q    <= 1'b0;
      last_q    <= '0;
      locked_q  <= 1'b0;
      seen_q    <= 1'b0;
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      trig_q    <= 1'b0;
    end else begin
      hs_dly_q  <= hs_lvl;
      oe_dly_q  <= oe_lvl;
      hs_ev_q   <= hs_ev_d;
      odd_ev_q  <= odd_ev_d;
      even_ev_q <= even_ev_d;
      line_q    <= line_d;
      fodd_q    <= fodd_d;
      last_q    <= last_d;
      locked_q  <= locked_d;
      seen_q    <= seen_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      trig_q    <= trig_d;
    end
  end

  assign trig       = trig_q;
  assign line_cnt   = line_q;
  assign field_odd  = fodd_q;
  assign lines_last = last_q;
  assign locked     = locked_q;
endmodule

// File: tb/tb_tv_trig_gen.sv
// Scoreboard bench for tv_trig_gen: expected trigger cycles are queued at stimulus
// time and a negedge monitor pops and compares them whenever trig is high.

module tb_tv_trig_gen;
  localparam int LW = 11;
  localparam int HW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic          hs_in  = 1'b0;
  logic          oe_in  = 1'b0;
  logic          hs_pol = 1'b0;
  logic          oe_pol = 1'b0;
  logic          arm    = 1'b0;
  logic [2:0]    mode   = 3'd5;
  logic [1:0]    field_sel   = 2'b01;
  logic [LW-1:0] target_line = 11'd23;
  logic [HW-1:0] holdoff     = '0;

  logic          trig, field_odd, locked;
  logic [LW-1:0] line_cnt, lines_last;
  logic          s_trig, s_field_odd, s_locked;
  logic [3:0]    s_line_cnt, s_lines_last;

  tv_trig_gen #(.LINE_W(LW), .FILT_LEN(4), .HOLD_W(HW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .hs_in(hs_in), .oe_in(oe_in),
    .hs_pol(hs_pol), .oe_pol(oe_pol), .mode(mode), .field_sel(field_sel),
    .target_line(target_line), .holdoff(holdoff), .arm(arm), .trig(trig),
    .line_cnt(line_cnt), .field_odd(field_odd), .lines_last(lines_last), .locked(locked)
  );

  // Narrow instance sharing the same inputs, used for the saturation check.
  tv_trig_gen #(.LINE_W(4), .FILT_LEN(4), .HOLD_W(HW)) dut_small (
    .clk_in(clk_in), .rst_n(rst_n), .hs_in(hs_in), .oe_in(oe_in),
    .hs_pol(hs_pol), .oe_pol(oe_pol), .mode(3'd5), .field_sel(2'b00),
    .target_line(4'd0), .holdoff(16'd0), .arm(1'b0), .trig(s_trig),
    .line_cnt(s_line_cnt), .field_odd(s_field_odd), .lines_last(s_lines_last), .locked(s_locked)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every trig pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (trig) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trig_unexpected: got trig at cycle %0d expected none", cyc);
      end else begin
        exp_cyc = exp_q.pop_front();
        if (exp_cyc != cyc) begin
          errors++;
          $display("FAIL trig_cycle: got %0d expected %0d", cyc, exp_cyc);
        end
      end
    end
    if (s_trig) begin
      checks++;
      errors++;
      $display("FAIL small_trig: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Raw edge driven at cycle d is first sampled on the next edge; trig seen at d+8.
  task automatic hs_line(input int period, input bit expect_trig);
    if (expect_trig) exp_q.push_back(cyc + 8);
    hs_in = 1'b1;
    tick(6);
    hs_in = 1'b0;
    tick(period - 6);
  endtask

  task automatic lines(input int n, input int trig_at);
    for (int i = 1; i <= n; i++) hs_line(20, i == trig_at);
  endtask

  task automatic fld_edge(input bit odd, input bit expect_trig);
    if (expect_trig) exp_q.push_back(cyc + 8);
    oe_in = odd;
    tick(10);
  endtask

  initial begin
    // Reset with toggling inputs
    for (int i = 0; i < 3; i++) begin
      hs_in = ~hs_in;
      oe_in = ~oe_in;
      tick(1);
    end
    hs_in = 1'b0;
    oe_in = 1'b0;
    check("rst_trig", 32'(trig), 0);
    check("rst_line_cnt", 32'(line_cnt), 0);
    check("rst_field_odd", 32'(field_odd), 0);
    check("rst_lines_last", 32'(lines_last), 0);
    check("rst_locked", 32'(locked), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("post_rst_trig", 32'(trig), 0);
    end
    tick(4);

    // PAL-like fields, trigger on line 23 of odd fields only
    arm = 1'b1;
    mode = 3'd4;
    tick(3);
    fld_edge(1'b1, 1'b0);
    check("f1_line_cnt", 32'(line_cnt), 0);
    check("f1_field_odd", 32'(field_odd), 1);
    check("f1_lines_last", 32'(lines_last), 0);
    check("f1_locked", 32'(locked), 0);
    lines(312, 23);
    check("f1_end_line_cnt", 32'(line_cnt), 312);
    fld_edge(1'b0, 1'b0);
    check("f2_field_odd", 32'(field_odd), 0);
    check("f2_lines_last", 32'(lines_last), 312);
    check("f2_locked", 32'(locked), 0);
    lines(312, 0);
    fld_edge(1'b1, 1'b0);
    check("f3_lines_last", 32'(lines_last), 312);
    check("f3_locked", 32'(locked), 1);
    lines(312, 23);
    fld_edge(1'b0, 1'b0);
    check("f4_locked", 32'(locked), 1);
    lines(313, 0);
    check("f4_end_line_cnt", 32'(line_cnt), 313);
    fld_edge(1'b1, 1'b0);
    check("f5_lines_last", 32'(lines_last), 313);
    check("f5_locked", 32'(locked), 0);
    lines(25, 23);

    // Coincident HS and field edge
    mode = 3'd5;
    tick(2);
    oe_in = 1'b0;
    hs_line(20, 1'b0);
    check("coinc_line_cnt", 32'(line_cnt), 1);
    check("coinc_field_odd", 32'(field_odd), 0);
    check("coinc_lines_last", 32'(lines_last), 25);

    // Glitch filter: 3-cycle pulse rejected, 4-cycle pulse counted
    hs_in = 1'b1;
    tick(3);
    hs_in = 1'b0;
    tick(15);
    check("glitch3_line_cnt", 32'(line_cnt), 1);
    hs_in = 1'b1;
    tick(4);
    hs_in = 1'b0;
    tick(15);
    check("glitch4_line_cnt", 32'(line_cnt), 2);

    // Saturation of the 4-bit instance
    lines(20, 0);
    check("sat_line_cnt_wide", 32'(line_cnt), 22);
    check("sat_line_cnt_small", 32'(s_line_cnt), 15);

    // Hold-off equal to line period: every other line triggers
    mode = 3'd3;
    holdoff = 16'd640;
    tick(2);
    for (int k = 0; k < 6; k++) hs_line(640, (k % 2) == 0);
    holdoff = 16'd0;
    tick(2);
    for (int k = 0; k < 4; k++) hs_line(20, 1'b1);

    // Arm low during hold-off clears it; HS while disarmed is ignored
    holdoff = 16'd100;
    tick(2);
    hs_line(20, 1'b1);
    arm = 1'b0;
    tick(3);
    arm = 1'b1;
    tick(5);
    hs_line(20, 1'b1);
    arm = 1'b0;
    hs_line(20, 1'b0);
    arm = 1'b1;
    tick(5);

    // Field modes
    holdoff = 16'd0;
    mode = 3'd0;
    tick(2);
    fld_edge(1'b1, 1'b0);
    fld_edge(1'b0, 1'b1);
    mode = 3'd1;
    tick(2);
    fld_edge(1'b1, 1'b1);
    check("mode1_field_odd", 32'(field_odd), 1);
    fld_edge(1'b0, 1'b0);
    mode = 3'd2;
    tick(2);
    fld_edge(1'b1, 1'b1);
    fld_edge(1'b0, 1'b1);

    tick(20);
    check("trig_queue_left", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tv_trig_gen.md
# tv_trig_gen

Parametrised second-generation TV/video trigger for the DSO trigger path. Conditions raw horizontal-sync and odd/even field comparator outputs, counts lines per field, and issues a single-cycle trigger on even field, odd field, any field start, any line, or one selected line qualified by field. Beyond the first-generation behaviour it adds sync polarity selection, a glitch filter, an arm input, trigger hold-off, lines-per-field measurement and a lock indicator, so one block covers PAL, NTSC and HD line counts.

## Interface
Parameters:
- LINE_W, 11, width of line counter and target line (up to 2047 lines, covers 1125-line HD)
- FILT_LEN, 4, consecutive stable samples required to accept a sync level change (min 1)
- HOLD_W, 16, width of hold-off counter

Ports:
- clk_in  in  1  trigger clock (10 MHz in the current build)
- rst_n  in  1  synchronous, active-low reset
- hs_in  in  1  raw horizontal sync, asynchronous to clk_in
- oe_in  in  1  raw odd/even field signal, asynchronous (high = odd field after polarity)
- hs_pol  in  1  1 = hs_in active-low
- oe_pol  in  1  1 = oe_in inverted
- mode  in  3  0 even field, 1 odd field, 2 any field, 3 any line, 4 certain line; 5-7 no trigger
- field_sel  in  2  certain-line qualifier: 01 odd only, 10 even only, 00/11 either field
- target_line  in  LINE_W  line number for mode 4 (line 1 = first HS of a field)
- holdoff  in  HOLD_W  clk_in cycles during which triggers are suppressed after a trigger
- arm  in  1  level; triggers issue only while high
- trig  out  1  one-cycle trigger pulse
- line_cnt  out  LINE_W  current line number within field
- field_odd  out  1  current field parity
- lines_last  out  LINE_W  line count of last completed field
- locked  out  1  two consecutive completed fields had equal line count

## Operation
- Input conditioning per input: XOR polarity, 2-FF synchroniser, filter counter; filtered level flips only after FILT_LEN consecutive synchronised samples at the new level; shorter pulses are discarded.
- Events (single-cycle, registered): hs_ev on filtered HS leading edge; odd_ev on filtered OE rising edge; even_ev on filtered OE falling edge; fld_ev = odd_ev | even_ev.
- Line counter: on fld_ev, line_cnt <= 0, field_odd <= odd_ev; on hs_ev, line_cnt <= line_cnt+1, saturating at all-ones. hs_ev and fld_ev in the same cycle: field edge applied first, HS counted, line_cnt = 1.
- Measurement: on fld_ev, lines_last <= line_cnt (value before clear); locked <= (line_cnt == lines_last) and at least two fld_ev seen since reset, else 0. First fld_ev after reset never updates locked to 1.
- Hit conditions (combinational from events): mode 0 even_ev; 1 odd_ev; 2 fld_ev; 3 hs_ev; 4 hs_ev and next line_cnt == target_line and field qualifier true. target_line = 0 never matches.
- Control FSM: IDLE (arm low) -> READY when arm high; READY -> on hit: trig pulse, load hold counter with holdoff, go HOLD (or stay READY if holdoff = 0); HOLD decrements each cycle, returns to READY at zero, hits ignored meanwhile; arm low in any state -> IDLE next cycle, hold counter cleared.
- mode/target_line/field_sel changes take effect on the next cycle; no effect on counters.

## Timing
- Reset (rst_n low at clk_in edge): trig 0, line_cnt 0, field_odd 0, lines_last 0, locked 0, filters/synchronisers to inactive level, FSM IDLE, hold counter 0.
- Latency: raw input edge first sampled at cycle 0 and held stable -> filtered level at cycle FILT_LEN+1 -> event at FILT_LEN+2 -> trig high at cycle FILT_LEN+3 (7 cycles for FILT_LEN=4), one cycle wide.
- line_cnt/field_odd/lines_last/locked update the same cycle trig would assert for that event.
- After trig at cycle T with holdoff = H > 0, earliest next trig is cycle T+H+1.
- Reset mid-field: counting restarts; line_cnt stays 0 until next fld_ev then counts normally; HS before first field edge increments from 0.

## Test plan
- Reset: hold rst_n low 3 cycles with toggling inputs -> all outputs 0, no trig for 6 cycles after release.
- PAL-like stimulus, mode 4, target_line 23, field_sel 01, arm 1 -> exactly one trig per odd field, 7 cycles after the 23rd HS edge; none in even fields.
- Glitch: 3-cycle HS pulse with FILT_LEN 4 -> no hs_ev, line_cnt unchanged; 4-cycle pulse -> counted.
- Hold-off: mode 3, holdoff 640, HS period 640 -> trig on every other line; holdoff 0 -> every line.
- Measurement: two fields of 312 lines then one of 313 -> lines_last 312, locked 1, then lines_last 313, locked 0; HS and OE edges coincident -> line_cnt 1.
- Saturation/arm: LINE_W 4, 20 HS without field edge -> line_cnt holds 15; arm low during HOLD -> IDLE, no trig, re-arm -> trig on next hit.
